seq_mul: RTL and testbench
==========================

Name: seq_mul

Overview:
- Parametrised, sequential successor to the team's 4-bit multiplier DUT.
- Radix-2 shift-and-add multiplier with operand width set by parameter and per-transaction signed/unsigned mode.
- Valid/ready handshakes on the input and output sides.
- Sits behind the multiplier interface; the UVM driver feeds operands and the monitor samples accepted products.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 2; product is 2*WIDTH bits.
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands a, b, signed_mode are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  y holds a completed product.
- out_ready  in  1  consumer accepts y.
- y  out  2*WIDTH  product.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low at a clk edge), state IDLE:
  - in_ready=1, out_valid=0, y=0, busy=0.
  - Internal accumulator, counter and operand registers cleared.
  - Reset mid-CALC or mid-DONE abandons the operation; no out_valid pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge T, latch operands and go to CALC.
  - Signed mode (signed_mode && SIGNED_EN): latch |a| and |b|, plus neg = a[MSB] ^ b[MSB].
  - Unsigned mode: latch operands as-is, neg = 0.
- CALC:
  - in_ready=0; exactly WIDTH cycles; counter runs 0..WIDTH-1.
  - Each cycle: if the current multiplier LSB is 1, add the shifted multiplicand into a 2*WIDTH accumulator; then shift.
  - On the final cycle, register y = neg ? -acc : acc, truncated to 2*WIDTH bits, and go to DONE.
- DONE:
  - out_valid=1; y is stable until handshake.
  - On out_ready, go to IDLE at that edge; out_valid drops next cycle.
  - out_ready is ignored when out_valid=0.
- Latency: accept at edge T; out_valid high from the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles after the input handshake cycle.
- Throughput: one product per WIDTH+2 cycles when out_ready is held high.
- No overlap: in_ready is low in CALC and DONE, and in_valid is ignored there.
- in_ready is a pure function of state (IDLE); it has no combinational path from in_valid or out_ready.
- Magnitude of the most negative value (-2^(WIDTH-1)) is held in WIDTH bits as an unsigned magnitude. The product magnitude fits in 2*WIDTH bits, so there is no overflow in either mode.
- Zero operand: still takes the full WIDTH cycles; y=0, never -0 artefacts.
- y holds its last value after the handshake until the next product is registered.
- Simultaneous out_ready and a new in_valid in DONE: only the output handshake completes; the input is accepted in the following IDLE cycle.

Decomposition:
- Package mul_pkg holds:
  - state typedef enum {IDLE, CALC, DONE}.
  - Localparam helper PROD_W(w) = 2*w.
  - Default WIDTH constant, shared with the interface and testbench.
- One natural sub-module: seq_mul_dp, the datapath. It contains:
  - Operand and magnitude registers.
  - Accumulator, shift logic and final negation.
  - It is controlled by the FSM in seq_mul via load/step/finish strobes.
- The multiplier interface is generalised to WIDTH, adding clk, rst_n and the handshake signals.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, y=0, busy=0; no operand accepted.
- Unsigned, WIDTH=4: a=15, b=15, signed_mode=0 -> after 5 cycles out_valid=1, y=225 (8'hE1); hold out_ready=0 for 4 cycles -> y stays 225.
- Signed, WIDTH=4:
  - a=4'b1000 (-8), b=4'b1000 (-8) -> y=64.
  - a=-8, b=7 -> y=8'hC8 (-56).
  - a=0, b=-1 -> y=0.
- SIGNED_EN=0, signed_mode=1: a=15, b=2 -> y=30 (unsigned).
- Back-to-back with out_ready=1: three transactions (3*5, 12*12, 1*0) -> y=15, 144, 0 in order; in_valid asserted during CALC is not accepted; in_ready asserted 6 cycles apart.
- Reset mid-CALC: accept 9*9, assert rst_n=0 at cycle 2 -> no out_valid. Then 2*3 -> y=6 with normal latency.
- WIDTH=8 regression: 255*255 unsigned -> y=16'hFE01; -128*-128 signed -> y=16'h4000.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller states, product-width helper and the default operand width.
package mul_pkg;

  // Default operand width, shared with the interface and the bench.
  localparam int DEF_WIDTH = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product width for a given operand width.
  function automatic int PROD_W(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Datapath of the sequential multiplier: operand magnitudes, shifted
// multiplicand, accumulator and the final sign fix-up into the result
// register. Sequenced by load/step/finish strobes from the controller.
module seq_mul_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load,
  input  logic                        i_step,
  input  logic                        i_finish,
  input  logic                        i_sgn,
  input  logic [WIDTH-1:0]            i_a,
  input  logic [WIDTH-1:0]            i_b,
  output logic [PROD_W(WIDTH)-1:0]    o_y
);

  localparam int PW = PROD_W(WIDTH);

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic             r_neg;
  logic [PW-1:0]    r_y;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg_in;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_prod;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits
  // because the magnitude is treated as unsigned from here on.
  always_comb begin
    w_a_mag  = i_a;
    w_b_mag  = i_b;
    w_neg_in = 1'b0;
    if (i_sgn) begin
      if (i_a[WIDTH-1]) w_a_mag = ~i_a + 1'b1;
      if (i_b[WIDTH-1]) w_b_mag = ~i_b + 1'b1;
      w_neg_in = i_a[WIDTH-1] ^ i_b[WIDTH-1];
    end
  end

  // One radix-2 partial product per step, and the signed result formed
  // from the accumulator value of the final step (so it lands with DONE).
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
    w_prod = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  end

  // Operand/accumulator registers; y only changes when a product completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_y      <= '0;
    end else begin
      if (i_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_neg    <= w_neg_in;
      end else if (i_step) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (i_finish) begin
        r_y <= w_prod;
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/seq_mul.sv
// Sequential radix-2 shift-and-add multiplier with valid/ready handshakes.
// One product every WIDTH+2 cycles; no overlap between transactions.
module seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        signed_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PROD_W(WIDTH)-1:0]    y,
  output logic                        busy
);

  localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_sgn;

  assign w_sgn = signed_mode & SIGNED_EN;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Step counter: restarts on every accepted operand pair.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + 1'b1;
  end

  // Next state, datapath strobes and handshake outputs; all decoded from
  // state only, so in_ready has no path from in_valid or out_ready.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  seq_mul_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_finish (w_finish),
    .i_sgn    (w_sgn),
    .i_a      (a),
    .i_b      (b),
    .o_y      (y)
  );

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: three instances (WIDTH=4 signed-capable, WIDTH=4 with
// signed mode disabled, WIDTH=8) driven one at a time through a scoreboard.
module tb_seq_mul;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_drv;
  logic [7:0] b_drv;
  logic       sm_drv;
  logic [2:0] iv;
  logic [2:0] ordy;
  wire  [2:0] irdy;
  wire  [2:0] ov;
  wire  [2:0] bsy;
  wire  [7:0] y0;
  wire  [7:0] y1;
  wire  [15:0] y2;

  logic [1:0]  sel;
  logic        w_irdy, w_ov, w_busy;
  logic [15:0] w_y;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  seq_mul #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .signed_mode(sm_drv),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y(y0), .busy(bsy[0]));

  seq_mul #(.WIDTH(4), .SIGNED_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .signed_mode(sm_drv),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y(y1), .busy(bsy[1]));

  seq_mul #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a_drv), .b(b_drv), .signed_mode(sm_drv),
    .out_valid(ov[2]), .out_ready(ordy[2]), .y(y2), .busy(bsy[2]));

  assign w_irdy = irdy[sel];
  assign w_ov   = ov[sel];
  assign w_busy = bsy[sel];
  assign w_y    = (sel == 2'd2) ? y2 : {8'h00, ((sel == 2'd1) ? y1 : y0)};

  function automatic int cur_w();
    return (sel == 2'd2) ? 8 : 4;
  endfunction

  // Reference product: plain integer multiply, reduced to 2*w bits.
  function automatic logic [15:0] model(input int av, input int bv, input bit sm);
    int w, sa, sb, p, mask;
    bit sen;
    w    = cur_w();
    sen  = (sel != 2'd1);
    sa   = av;
    sb   = bv;
    if (sm && sen) begin
      if (av >= (1 << (w - 1))) sa = av - (1 << w);
      if (bv >= (1 << (w - 1))) sb = bv - (1 << w);
    end
    p    = sa * sb;
    mask = (1 << (2 * w)) - 1;
    return 16'(p & mask);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int av, input int bv, input bit sm);
    int k;
    a_drv  = 8'(av);
    b_drv  = 8'(bv);
    sm_drv = sm;
    iv     = '0;
    iv[sel] = 1'b1;
    k = 0;
    while (!w_irdy && k < 20) begin
      step();
      k++;
    end
    if (!w_irdy) begin
      chk("send_timeout", 16'(w_irdy), 16'h1);
      iv = '0;
    end else begin
      sb_q.push_back(model(av, bv, sm));
      step();
      iv = '0;
      chk("calc_in_ready", 16'(w_irdy), 16'h0);
      chk("calc_busy", 16'(w_busy), 16'h1);
    end
  endtask

  task automatic recv(input int hold);
    int k;
    logic [15:0] held, exp;
    ordy = '0;
    k = 0;
    while (!w_ov && k < 20) begin
      step();
      k++;
    end
    if (!w_ov) begin
      chk("recv_timeout", 16'(w_ov), 16'h1);
    end else begin
      chk("latency", 16'(k), 16'(cur_w()));
      chk("done_busy", 16'(w_busy), 16'h1);
      held = w_y;
      for (int h = 0; h < hold; h++) begin
        step();
        chk("hold_valid", 16'(w_ov), 16'h1);
        chk("hold_y", w_y, held);
      end
      if (sb_q.size() == 0) begin
        chk("sb_empty", 16'(sb_q.size()), 16'h1);
      end else begin
        exp = sb_q.pop_front();
        chk("y", w_y, exp);
        ordy[sel] = 1'b1;
        step();
        ordy = '0;
        chk("valid_drop", 16'(w_ov), 16'h0);
        chk("idle_ready", 16'(w_irdy), 16'h1);
        chk("y_kept", w_y, exp);
      end
    end
  endtask

  initial begin
    int opa[3];
    int opb[3];
    int idx, nout, last, seen;
    bit acc;
    logic [15:0] e;
    opa = '{3, 12, 1};
    opb = '{5, 12, 0};

    // Reset with in_valid held high on every instance.
    sel = 2'd0; rst_n = 1'b0; iv = 3'b111; ordy = '0;
    a_drv = 8'd3; b_drv = 8'd3; sm_drv = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 16'(irdy), 16'h7);
    chk("rst_out_valid", 16'(ov), 16'h0);
    chk("rst_busy", 16'(bsy), 16'h0);
    chk("rst_y0", 16'(y0), 16'h0);
    chk("rst_y1", 16'(y1), 16'h0);
    chk("rst_y2", y2, 16'h0);
    iv = '0;
    rst_n = 1'b1;
    step();
    chk("rst_no_accept", 16'(bsy), 16'h0);

    // WIDTH=4, signed-capable instance.
    sel = 2'd0;
    send(15, 15, 1'b0); recv(4);
    send(8, 8, 1'b1);   recv(0);
    send(8, 7, 1'b1);   recv(1);
    send(0, 15, 1'b1);  recv(0);

    // Signed mode disabled: signed_mode=1 must still multiply unsigned.
    sel = 2'd1;
    send(15, 2, 1'b1);  recv(0);
    send(8, 7, 1'b1);   recv(0);

    // WIDTH=8 regression.
    sel = 2'd2;
    send(255, 255, 1'b0); recv(0);
    send(128, 128, 1'b1); recv(0);
    send(128, 127, 1'b1); recv(0);

    // Back-to-back with out_ready held high and in_valid never dropped
    // until the last pair has been accepted.
    sel = 2'd0;
    ordy = 3'b001;
    a_drv = 8'(opa[0]); b_drv = 8'(opb[0]); sm_drv = 1'b0;
    iv = 3'b001;
    idx = 0; nout = 0; last = 0;
    for (int c = 0; c < 60 && nout < 3; c++) begin
      acc = 1'b0;
      if (w_ov) begin
        if (sb_q.size() == 0) begin
          chk("b2b_sb_empty", 16'(sb_q.size()), 16'h1);
        end else begin
          e = sb_q.pop_front();
          chk("b2b_y", w_y, e);
        end
        nout++;
      end
      if (w_irdy && idx < 3) begin
        if (idx > 0) chk("b2b_ready_gap", 16'(c - last), 16'd6);
        last = c;
        sb_q.push_back(model(opa[idx], opb[idx], 1'b0));
        acc = 1'b1;
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          a_drv = 8'(opa[idx]);
          b_drv = 8'(opb[idx]);
        end else begin
          iv = '0;
        end
      end
    end
    iv = '0;
    ordy = '0;
    chk("b2b_count", 16'(nout), 16'd3);
    chk("b2b_accepts", 16'(idx), 16'd3);

    // Reset two cycles into CALC: the product is abandoned.
    sel = 2'd0;
    send(9, 9, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (w_ov) seen = 1;
      step();
    end
    chk("abort_no_valid", 16'(seen), 16'h0);
    chk("abort_ready", 16'(w_irdy), 16'h1);
    send(2, 3, 1'b0); recv(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
